// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT address generator: FSM state encoding and
// default transform geometry.
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } ntt_state_t;

  localparam int NTT_LOG_N      = 8;
  localparam int NTT_ADDR_WIDTH = 17;

endpackage

// File: rtl/ntt_bfly_cnt.sv
// Nested stage / group / in-group counters for the NTT butterfly schedule.
// Holds the indices of the pair currently presented and exposes its successor.
module ntt_bfly_cnt #(
  parameter int log_n = 8,
  parameter int SW    = $clog2(log_n)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic             inv,
  output logic [SW-1:0]    stg,
  output logic [log_n-1:0] g,
  output logic [log_n-1:0] j,
  output logic [SW-1:0]    stg_nxt,
  output logic [log_n-1:0] g_nxt,
  output logic [log_n-1:0] j_nxt,
  output logic             stage_last,
  output logic             final_stage
);

  logic [SW-1:0]    hl;
  logic [log_n-1:0] j_max;
  logic [log_n-1:0] g_max;
  logic             j_last;
  logic             g_last;

  // hl = log2(half) for the current stage; groups take the remaining bits.
  always_comb begin
    hl    = inv ? stg : SW'(log_n - 1) - stg;
    j_max = (log_n'(1) << hl) - log_n'(1);
    g_max = (log_n'(1) << (SW'(log_n - 1) - hl)) - log_n'(1);
  end

  assign j_last      = (j == j_max);
  assign g_last      = (g == g_max);
  assign stage_last  = j_last & g_last;
  assign final_stage = (stg == SW'(log_n - 1));

  always_comb begin
    stg_nxt = stg;
    g_nxt   = g;
    j_nxt   = j + log_n'(1);
    if (j_last) begin
      j_nxt = '0;
      g_nxt = g + log_n'(1);
      if (g_last) begin
        g_nxt   = '0;
        stg_nxt = stg + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
      g   <= '0;
      j   <= '0;
    end else if (clr) begin
      stg <= '0;
      g   <= '0;
      j   <= '0;
    end else if (step) begin
      stg <= stg_nxt;
      g   <= g_nxt;
      j   <= j_nxt;
    end
  end

endmodule

// File: rtl/ntt_addr_gen.sv
// NTT butterfly address / twiddle generator with stage gaps and stall.
// Define NTT_ADDR_GEN_INV_EN to support inverse (Gentleman-Sande) ordering.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int log_n      = NTT_LOG_N,
  parameter int addr_width = NTT_ADDR_WIDTH,
  parameter int stage_gap  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     inverse,
  input  logic                     stall,
  output logic [addr_width-1:0]    out0_addr,
  output logic [addr_width-1:0]    out1_addr,
  output logic                     out0_en,
  output logic                     out1_en,
  output logic                     mode,
  output logic [log_n-1:0]         tw_addr,
  output logic [$clog2(log_n)-1:0] stage,
  output logic                     busy,
  output logic                     done
);

  localparam int SW = $clog2(log_n);
  localparam int GW = $clog2(stage_gap + 2);

  typedef struct packed {
    logic [addr_width-1:0] a0;
    logic [addr_width-1:0] a1;
    logic [log_n-1:0]      tw;
    logic                  mode;
  } pair_t;

  ntt_state_t state, state_nxt;

  logic             load, use_nxt, cnt_clr, cnt_step, vld_nxt;
  logic             gap_clr, gap_inc, gap_last;
  logic [GW-1:0]    gap_cnt;
  logic             inv_in, inv_q, inv_src;

  logic [SW-1:0]    cnt_stg, cnt_stg_nxt, src_stg;
  logic [log_n-1:0] cnt_g, cnt_g_nxt, src_g;
  logic [log_n-1:0] cnt_j, cnt_j_nxt, src_j;
  logic             stage_last, final_stage;

  pair_t                 pair_nxt;
  logic [addr_width-1:0] out0_p0, out1_p0;
  logic [log_n-1:0]      tw_p0;
  logic                  mode_p0;
  logic                  vld_p0;

  function automatic pair_t pair_calc(input logic [SW-1:0]    s,
                                      input logic [log_n-1:0] gi,
                                      input logic [log_n-1:0] ji,
                                      input logic             inv);
    int unsigned hl, gl, half, base;
    pair_t p;
    if (inv) hl = 32'(s);
    else     hl = 32'(log_n - 1) - 32'(s);
    gl     = 32'(log_n - 1) - hl;
    half   = 32'd1 << hl;
    base   = (32'(gi) << (hl + 32'd1)) + 32'(ji);
    p.a0   = addr_width'(base);
    p.a1   = addr_width'(base + half);
    p.tw   = log_n'((32'd1 << gl) + 32'(gi));
    p.mode = (half <= 32'd2);
    return p;
  endfunction

`ifdef NTT_ADDR_GEN_INV_EN
  assign inv_in = inverse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      inv_q <= 1'b0;
    else if (state == IDLE && start) inv_q <= inverse;
  end
`else
  logic unused_inverse;
  assign unused_inverse = inverse;
  assign inv_in         = 1'b0;
  assign inv_q          = 1'b0;
`endif

  // The direction for the very first pair comes straight from the start cycle.
  assign inv_src = (state == IDLE) ? inv_in : inv_q;

  ntt_bfly_cnt #(
    .log_n (log_n),
    .SW    (SW)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (cnt_clr),
    .step        (cnt_step),
    .inv         (inv_src),
    .stg         (cnt_stg),
    .g           (cnt_g),
    .j           (cnt_j),
    .stg_nxt     (cnt_stg_nxt),
    .g_nxt       (cnt_g_nxt),
    .j_nxt       (cnt_j_nxt),
    .stage_last  (stage_last),
    .final_stage (final_stage)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    use_nxt   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_step  = 1'b0;
    vld_nxt   = vld_p0;
    gap_clr   = 1'b0;
    gap_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
          vld_nxt   = 1'b1;
        end
      end
      RUN: begin
        if (vld_p0 && !stall) begin
          if (!stage_last) begin
            cnt_step = 1'b1;
            load     = 1'b1;
            use_nxt  = 1'b1;
          end else if (final_stage) begin
            state_nxt = DONE;
            vld_nxt   = 1'b0;
            cnt_clr   = 1'b1;
          end else if (stage_gap == 0) begin
            cnt_step = 1'b1;
            load     = 1'b1;
            use_nxt  = 1'b1;
          end else begin
            cnt_step  = 1'b1;
            state_nxt = GAP;
            vld_nxt   = 1'b0;
            gap_clr   = 1'b1;
          end
        end
      end
      GAP: begin
        gap_inc = 1'b1;
        if (gap_last) begin
          state_nxt = RUN;
          load      = 1'b1;
          vld_nxt   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       gap_cnt <= '0;
    else if (gap_clr) gap_cnt <= '0;
    else if (gap_inc) gap_cnt <= gap_cnt + GW'(1);
  end

  assign gap_last = (32'(gap_cnt) + 32'd1) >= 32'(stage_gap);

  // Stage p0: pair arithmetic on the counter value about to be presented.
  always_comb begin
    src_stg  = use_nxt ? cnt_stg_nxt : cnt_stg;
    src_g    = use_nxt ? cnt_g_nxt   : cnt_g;
    src_j    = use_nxt ? cnt_j_nxt   : cnt_j;
    pair_nxt = pair_calc(src_stg, src_g, src_j, inv_src);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_p0 <= '0;
      out1_p0 <= '0;
      tw_p0   <= '0;
      mode_p0 <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= vld_nxt;
      if (load) begin
        out0_p0 <= pair_nxt.a0;
        out1_p0 <= pair_nxt.a1;
        tw_p0   <= pair_nxt.tw;
        mode_p0 <= pair_nxt.mode;
      end
    end
  end

  // A held pair stays on the bus and only counts as issued once stall drops.
  assign out0_addr = out0_p0;
  assign out1_addr = out1_p0;
  assign tw_addr   = tw_p0;
  assign mode      = mode_p0;
  assign out0_en   = vld_p0 & ~stall;
  assign out1_en   = vld_p0 & ~stall;
  assign stage     = cnt_stg;
  assign busy      = (state == RUN) || (state == GAP);
  assign done      = (state == DONE);

endmodule
